pito_sim_watchdog: RTL and testbench

//  Parametrised run monitor for the pito bench. Supersedes the fixed 1 ms

---
 rtl/pito_sim_watchdog.sv | 200 ++++++++++++++++++++
 tb/tb_pito_sim_watchdog.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pito_sim_watchdog.sv
// ---------------------------------------------------------------------------
// pito_sim_watchdog
//
// Cycle-accurate run monitor for the pito bench. It counts cycles spent in
// RUN, accumulates per-hart completion, tracks per-hart retire inactivity and
// reports the run outcome: PASS, TIMEOUT, HANG or ABORTED.
//
// Optional feature macro: PITO_WDOG_TRACE_EN
//   When defined, every state change is printed and the extra output
//   retire_total_o (saturating sum of retire bits in RUN) is added.
//
// Ports
//   clk_i          in   1          bench clock, rising edge
//   rst_ni         in   1          asynchronous active-low reset
//   start_i        in   1          pulse: clear run state and enter RUN
//   abort_i        in   1          level: tester requests stop
//   retire_i       in   NUM_HARTS  per-hart instruction-retired strobe
//   done_i         in   NUM_HARTS  per-hart completion (made sticky here)
//   busy_o         out  1          1 while in RUN
//   finished_o     out  1          1 in any terminal state
//   status_o       out  3          0 IDLE 1 RUN 2 PASS 3 TIMEOUT 4 HANG 5 ABORTED
//   cycle_count_o  out  CNT_W      cycles spent in RUN, frozen when terminal
//   done_mask_o    out  NUM_HARTS  sticky done bits
//   hang_mask_o    out  NUM_HARTS  harts at the hang limit on HANG entry
//   retire_total_o out  CNT_W      (PITO_WDOG_TRACE_EN only) retire total
// ---------------------------------------------------------------------------
module pito_sim_watchdog #(
  parameter int NUM_HARTS    = 8,
  parameter int CNT_W        = 32,
  parameter int GLOBAL_LIMIT = 10000,
  parameter int HANG_LIMIT   = 2000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [NUM_HARTS-1:0] retire_i,
  input  logic [NUM_HARTS-1:0] done_i,
  output logic                 busy_o,
  output logic                 finished_o,
  output logic [2:0]           status_o,
  output logic [CNT_W-1:0]     cycle_count_o,
  output logic [NUM_HARTS-1:0] done_mask_o,
`ifdef PITO_WDOG_TRACE_EN
  output logic [CNT_W-1:0]     retire_total_o,
`endif
  output logic [NUM_HARTS-1:0] hang_mask_o
);

  // Elaboration-time sanity checks on the configuration.
  if ((64'(GLOBAL_LIMIT) >= (64'd1 << CNT_W)) ||
      (64'(HANG_LIMIT) >= (64'd1 << CNT_W))) begin : g_limit_err
    $fatal(1, "pito_sim_watchdog: GLOBAL_LIMIT and HANG_LIMIT must be < 2**CNT_W");
  end
  if ((NUM_HARTS < 1) || (NUM_HARTS > 32)) begin : g_harts_err
    $fatal(1, "pito_sim_watchdog: NUM_HARTS must be in 1..32");
  end
  if ((GLOBAL_LIMIT < 1) || (HANG_LIMIT < 1)) begin : g_min_err
    $fatal(1, "pito_sim_watchdog: limits must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4,
    ST_ABORTED = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] GLOBAL_LAST = CNT_W'(GLOBAL_LIMIT - 1);
  localparam logic [CNT_W-1:0] HANG_LIM    = CNT_W'(HANG_LIMIT);

  state_e                 state_q;
  logic                   busy_q;
  logic                   finished_q;
  logic [CNT_W-1:0]       cycle_count_q;
  logic [CNT_W-1:0]       cycle_count_d;
  logic [NUM_HARTS-1:0]   done_mask_q;
  logic [NUM_HARTS-1:0]   hang_mask_q;
  logic [NUM_HARTS-1:0]   hang_hit;
  logic [CNT_W-1:0]       hang_cnt_q [NUM_HARTS];

  // The run always leaves RUN at GLOBAL_LIMIT, so this increment cannot wrap.
  assign cycle_count_d = cycle_count_q + CNT_W'(1);

  // Per-hart inactivity counters. A finished hart can never hang, so its
  // sticky done bit holds the counter at zero just like a retire does.
  for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hang
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hang_cnt_q[gi] <= '0;
      end else if (start_i) begin
        hang_cnt_q[gi] <= '0;
      end else if (state_q == ST_RUN) begin
        if (retire_i[gi] || done_mask_q[gi]) begin
          hang_cnt_q[gi] <= '0;
        end else if (hang_cnt_q[gi] != HANG_LIM) begin
          hang_cnt_q[gi] <= hang_cnt_q[gi] + CNT_W'(1);
        end
      end
    end
    assign hang_hit[gi] = (hang_cnt_q[gi] == HANG_LIM);
  end

`ifdef PITO_WDOG_TRACE_EN
  logic [CNT_W-1:0] retire_total_q;
  logic [CNT_W-1:0] retire_total_d;
  logic [CNT_W:0]   retire_sum;
  logic [CNT_W-1:0] retire_pop;

  always_comb begin
    retire_pop = '0;
    for (int k = 0; k < NUM_HARTS; k++) begin
      retire_pop = retire_pop + CNT_W'(retire_i[k]);
    end
    retire_sum = {1'b0, retire_total_q} + {1'b0, retire_pop};
    // Saturate instead of wrapping on carry out.
    retire_total_d = retire_sum[CNT_W] ? '1 : retire_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_total_q <= '0;
    end else if (start_i) begin
      retire_total_q <= '0;
    end else if (state_q == ST_RUN) begin
      retire_total_q <= retire_total_d;
    end
  end

  assign retire_total_o = retire_total_q;

  // Trace of state changes; reported one edge after the change so the
  // printed counters are those of the new state.
  state_e trace_prev_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trace_prev_q <= ST_IDLE;
    end else begin
      trace_prev_q <= state_q;
      if (trace_prev_q != state_q) begin
        $display("[WDOG] %t %s->%s cyc=%0d done=%b hang=%b", $time,
                 trace_prev_q.name(), state_q.name(), cycle_count_q,
                 done_mask_q, hang_mask_q);
      end
    end
  end
`endif

  // Main FSM with registered outputs. start_i restarts from any state,
  // including RUN. Exit checks use registered values only, so status moves
  // one edge after the condition is visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
      cycle_count_q <= '0;
      done_mask_q   <= '0;
      hang_mask_q   <= '0;
    end else if (start_i) begin
      state_q       <= ST_RUN;
      busy_q        <= 1'b1;
      finished_q    <= 1'b0;
      cycle_count_q <= '0;
      done_mask_q   <= '0;
      hang_mask_q   <= '0;
    end else if (state_q == ST_RUN) begin
      cycle_count_q <= cycle_count_d;
      done_mask_q   <= done_mask_q | done_i;
      if (&done_mask_q) begin
        state_q    <= ST_PASS;
        busy_q     <= 1'b0;
        finished_q <= 1'b1;
      end else if (abort_i) begin
        state_q    <= ST_ABORTED;
        busy_q     <= 1'b0;
        finished_q <= 1'b1;
      end else if (cycle_count_q == GLOBAL_LAST) begin
        state_q    <= ST_TIMEOUT;
        busy_q     <= 1'b0;
        finished_q <= 1'b1;
      end else if (|hang_hit) begin
        state_q     <= ST_HANG;
        busy_q      <= 1'b0;
        finished_q  <= 1'b1;
        hang_mask_q <= hang_hit;
      end
    end
  end

  assign busy_o        = busy_q;
  assign finished_o    = finished_q;
  assign status_o      = state_q;
  assign cycle_count_o = cycle_count_q;
  assign done_mask_o   = done_mask_q;
  assign hang_mask_o   = hang_mask_q;

endmodule

// File: tb/tb_pito_sim_watchdog.sv
// ---------------------------------------------------------------------------
// tb_pito_sim_watchdog
//
// Directed bench for pito_sim_watchdog with default parameters (8 harts,
// GLOBAL_LIMIT 10000, HANG_LIMIT 2000). The stimulus process queues the
// expected snapshot for every status change it provokes; the monitor process
// pops one entry each time status_o changes and compares all outputs.
// ---------------------------------------------------------------------------
module tb_pito_sim_watchdog;

  localparam int NH = 8;
  localparam int CW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic          abort_i;
  logic [NH-1:0] retire_i;
  logic [NH-1:0] done_i;
  logic          busy_o;
  logic          finished_o;
  logic [2:0]    status_o;
  logic [CW-1:0] cycle_count_o;
  logic [NH-1:0] done_mask_o;
  logic [NH-1:0] hang_mask_o;
`ifdef PITO_WDOG_TRACE_EN
  logic [CW-1:0] retire_total_o;
`endif

  pito_sim_watchdog #(
    .NUM_HARTS   (NH),
    .CNT_W       (CW),
    .GLOBAL_LIMIT(10000),
    .HANG_LIMIT  (2000)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .retire_i      (retire_i),
    .done_i        (done_i),
    .busy_o        (busy_o),
    .finished_o    (finished_o),
    .status_o      (status_o),
    .cycle_count_o (cycle_count_o),
    .done_mask_o   (done_mask_o),
`ifdef PITO_WDOG_TRACE_EN
    .retire_total_o(retire_total_o),
`endif
    .hang_mask_o   (hang_mask_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [2:0]  status;
    int          lag;     // extra negedges to wait after the change
    logic [31:0] count;
    logic [7:0]  dmask;
    logic [7:0]  hmask;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push_exp(input string nm, input logic [2:0] st, input int lag,
                          input int cnt, input logic [7:0] dm, input logic [7:0] hm);
    exp_t e;
    e.name = nm; e.status = st; e.lag = lag;
    e.count = cnt; e.dmask = dm; e.hmask = hm;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, field, act, req);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // One-cycle start pulse; returns in the first RUN cycle (count 0).
  task automatic pulse_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  // Monitor: one comparison set per status change.
  initial begin : monitor
    logic [2:0] last_st;
    exp_t       e;
    last_st = 3'b111;
    forever begin
      @(negedge clk_i);
      if (status_o !== last_st) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_change status actual=%0d required=no change", status_o);
          last_st = status_o;
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < e.lag; i++) @(negedge clk_i);
          last_st = status_o;
          chk(e.name, "status",   32'(status_o),      32'(e.status));
          chk(e.name, "busy",     32'(busy_o),        32'(e.status == 3'd1));
          chk(e.name, "finished", 32'(finished_o),    32'(e.status >= 3'd2));
          chk(e.name, "cycle",    cycle_count_o,      e.count);
          chk(e.name, "done_mask", 32'(done_mask_o),  32'(e.dmask));
          chk(e.name, "hang_mask", 32'(hang_mask_o),  32'(e.hmask));
          $display("txn %-10s status=%0d cyc=%0d done=%02h hang=%02h", e.name,
                   status_o, cycle_count_o, done_mask_o, hang_mask_o);
        end
      end
    end
  end

  initial begin : stimulus
    int wait_cnt;
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    abort_i  = 1'b0;
    retire_i = '0;
    done_i   = '0;
    push_exp("reset", 3'd0, 0, 0, 8'h00, 8'h00);
    #12 rst_ni = 1'b1;
    tick(2);

    // 1: all done in the fifth RUN cycle -> PASS two edges later, count 6.
    push_exp("t1_run", 3'd1, 0, 0, 8'h00, 8'h00);
    pulse_start();
    tick(4);
    push_exp("t1_pass", 3'd2, 0, 6, 8'hFF, 8'h00);
    done_i = '1;
    tick(1);
    done_i = '0;
    tick(4);

    // 6: restart from PASS clears the mask and the counter.
    push_exp("t6_run", 3'd1, 0, 0, 8'h00, 8'h00);
    pulse_start();
    retire_i = '1;
    tick(20);

    // 2: restart while in RUN, then retire forever -> TIMEOUT at 10000.
    push_exp("t2_tmo", 3'd3, 0, 10000, 8'h00, 8'h00);
    pulse_start();
    tick(10003);

    // 3: hart 3 stops retiring at cycle 100 -> HANG at 2101, mask 08.
    push_exp("t3_run", 3'd1, 0, 0, 8'h00, 8'h00);
    pulse_start();
    tick(100);
    push_exp("t3_hang", 3'd4, 0, 2101, 8'h00, 8'h08);
    retire_i = 8'hF7;
    tick(2105);
    retire_i = '0;

    // 4a: abort and all-done in the same cycle -> PASS wins.
    push_exp("t4_run", 3'd1, 0, 0, 8'h00, 8'h00);
    pulse_start();
    tick(2);
    push_exp("t4_pass", 3'd2, 0, 4, 8'hFF, 8'h00);
    done_i = '1;
    tick(1);
    done_i  = '0;
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    tick(3);

    // 4b: abort alone at cycle 50 with a partial done mask -> ABORTED.
    push_exp("t4b_run", 3'd1, 0, 0, 8'h00, 8'h00);
    pulse_start();
    tick(10);
    done_i = 8'h05;
    tick(1);
    done_i = '0;
    tick(39);
    push_exp("t4b_abort", 3'd5, 0, 51, 8'h05, 8'h00);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    tick(3);

    // 5: reset at RUN cycle 300, then a fresh run counts from 1.
    push_exp("t5_run", 3'd1, 0, 0, 8'h00, 8'h00);
    pulse_start();
    tick(300);
    push_exp("t5_reset", 3'd0, 0, 0, 8'h00, 8'h00);
    rst_ni = 1'b0;
    tick(2);
    rst_ni = 1'b1;
    tick(1);
    push_exp("t5_rerun", 3'd1, 1, 1, 8'h00, 8'h00);
    pulse_start();
    tick(3);
    push_exp("t5_pass", 3'd2, 0, 5, 8'hFF, 8'h00);
    done_i = '1;
    tick(1);
    done_i = '0;
    tick(4);

    // 7: nobody retires; done harts 0 and 7 are exempt -> mask 7E at 2001.
    push_exp("t7_run", 3'd1, 0, 0, 8'h00, 8'h00);
    pulse_start();
    push_exp("t7_hang", 3'd4, 0, 2001, 8'h81, 8'h7E);
    done_i = 8'h81;
    tick(1);
    done_i = '0;
    tick(2005);

    // Drain: every queued expectation must have been met.
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 100) begin
      tick(1);
      wait_cnt++;
    end
    while (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s.timeout actual=no status change required=status %0d",
               exp_q[0].name, exp_q[0].status);
      void'(exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
